// File: rtl/video_frame_reader.sv
// AXI3 read burst master: fetches a 2-D frame and streams it with line/frame
// markers through a credit-managed first-word-fall-through FIFO.
module video_frame_reader #(
   parameter int ADDR_W    = 32,
   parameter int DATA_W    = 64,
   parameter int ID_W      = 8,
   parameter int ARID_VAL  = 0,
   parameter int BURST_LEN = 16,
   parameter int MAX_OUTST = 4
) (
   input  logic              acr_clk,
   input  logic              acr_rst,
   input  logic              cfg_start,
   input  logic [ADDR_W-1:0] cfg_base,
   input  logic [ADDR_W-1:0] cfg_stride,
   input  logic [15:0]       cfg_line_beats,
   input  logic [15:0]       cfg_lines,
   output logic              busy,
   output logic              done,
   output logic              err,
   output logic [ID_W-1:0]   axi_arid,
   output logic [ADDR_W-1:0] axi_araddr,
   output logic [3:0]        axi_arlen,
   output logic [2:0]        axi_arsize,
   output logic [1:0]        axi_arburst,
   output logic              axi_arlock,
   output logic [3:0]        axi_arcache,
   output logic [2:0]        axi_arprot,
   output logic              axi_arvalid,
   input  logic              axi_arready,
   input  logic [ID_W-1:0]   axi_rid,
   input  logic [DATA_W-1:0] axi_rdata,
   input  logic [1:0]        axi_rresp,
   input  logic              axi_rlast,
   input  logic              axi_rvalid,
   output logic              axi_rready,
   output logic [DATA_W-1:0] pix_data,
   output logic              pix_valid,
   input  logic              pix_ready,
   output logic              pix_sol,
   output logic              pix_eol,
   output logic              pix_eof
);
   localparam int DEPTH = MAX_OUTST * BURST_LEN;
   localparam int CW    = $clog2(DEPTH + 1);
   localparam int PW    = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int SIZE  = $clog2(DATA_W / 8);
   localparam int FW    = DATA_W + 3;

   typedef enum logic [1:0] {IDLE, ISSUE, DRAIN} state_t;

   state_t            state_q, state_d;
   logic [ADDR_W-1:0] stride_q, stride_d;
   logic [ADDR_W-1:0] line_addr_q, line_addr_d;
   logic [ADDR_W-1:0] araddr_q, araddr_d;
   logic [15:0]       line_beats_q, line_beats_d;
   logic [15:0]       lines_q, lines_d;
   logic [15:0]       line_q, line_d;
   logic [15:0]       beats_left_q, beats_left_d;
   logic [15:0]       wbeat_q, wbeat_d;
   logic [15:0]       wline_q, wline_d;
   logic [CW-1:0]     credits_q, credits_d;
   logic [CW-1:0]     cnt_q, cnt_d;
   logic [PW-1:0]     wp_q, wp_d;
   logic [PW-1:0]     rp_q, rp_d;
   logic              err_q, err_d;
   logic              done_q, done_d;
   logic              rx_done_q, rx_done_d;
   logic [FW-1:0]     mem_q [DEPTH];
   logic [FW-1:0]     rd_word;
   logic [15:0]       len;
   logic              ar_hs, r_hs, pop;
   logic              wr_sol, wr_eol, wr_eof;
   logic              unused_in;

   assign unused_in = ^{axi_rid, axi_rlast};

   always_comb begin
      len = (beats_left_q >= 16'(BURST_LEN)) ? 16'(BURST_LEN) : beats_left_q;
      axi_arvalid = (state_q == ISSUE) && (credits_q >= CW'(len));
      axi_arlen = (state_q == ISSUE) ? 4'(len - 16'd1) : 4'd0;
      axi_rready = (state_q != IDLE);
      ar_hs = axi_arvalid & axi_arready;
      r_hs = axi_rvalid & axi_rready;
      pix_valid = (cnt_q != '0);
      pop = pix_valid & pix_ready;
      wr_sol = (wbeat_q == 16'd0);
      wr_eol = (wbeat_q == line_beats_q - 16'd1);
      wr_eof = wr_eol && (wline_q == lines_q - 16'd1);
      rd_word = pix_valid ? mem_q[rp_q] : '0;
   end

   assign {pix_eof, pix_eol, pix_sol, pix_data} = rd_word;
   assign busy        = (state_q != IDLE);
   assign done        = done_q;
   assign err         = err_q;
   assign axi_araddr  = araddr_q;
   assign axi_arid    = ID_W'(ARID_VAL);
   assign axi_arsize  = 3'(SIZE);
   assign axi_arburst = 2'b01;
   assign axi_arlock  = 1'b0;
   assign axi_arcache = 4'b0011;
   assign axi_arprot  = 3'b000;

   always_comb begin
      state_d      = state_q;
      stride_d     = stride_q;
      line_addr_d  = line_addr_q;
      araddr_d     = araddr_q;
      line_beats_d = line_beats_q;
      lines_d      = lines_q;
      line_d       = line_q;
      beats_left_d = beats_left_q;
      wbeat_d      = wbeat_q;
      wline_d      = wline_q;
      err_d        = err_q;
      done_d       = 1'b0;
      rx_done_d    = rx_done_q;
      credits_d    = credits_q + CW'(pop) - (ar_hs ? CW'(len) : CW'(0));
      cnt_d        = cnt_q + CW'(r_hs) - CW'(pop);
      wp_d         = wp_q;
      rp_d         = rp_q;
      unique case (state_q)
         IDLE: begin
            if (cfg_start) begin
               stride_d     = cfg_stride;
               line_beats_d = cfg_line_beats;
               lines_d      = cfg_lines;
               line_d       = 16'd0;
               line_addr_d  = cfg_base;
               araddr_d     = cfg_base;
               beats_left_d = cfg_line_beats;
               wbeat_d      = 16'd0;
               wline_d      = 16'd0;
               rx_done_d    = 1'b0;
               err_d        = 1'b0;
               state_d      = ISSUE;
            end
         end
         ISSUE: begin
            if (ar_hs) begin
               if (beats_left_q == len) begin
                  line_addr_d  = line_addr_q + stride_q;
                  araddr_d     = line_addr_q + stride_q;
                  beats_left_d = line_beats_q;
                  line_d       = line_q + 16'd1;
                  if (line_q == lines_q - 16'd1) state_d = DRAIN;
               end else begin
                  beats_left_d = beats_left_q - len;
                  araddr_d     = araddr_q + (ADDR_W'(len) << SIZE);
               end
            end
         end
         DRAIN: begin
            if (rx_done_q && (cnt_q == '0)) begin
               done_d  = 1'b1;
               state_d = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
      // markers are tagged on the write side so they travel with the data
      if (r_hs) begin
         wbeat_d = wr_eol ? 16'd0 : wbeat_q + 16'd1;
         wline_d = wline_q + 16'(wr_eol);
         wp_d    = (wp_q == PW'(DEPTH - 1)) ? '0 : wp_q + PW'(1);
         if (wr_eof) rx_done_d = 1'b1;
         if (axi_rresp != 2'b00) err_d = 1'b1;
      end
      if (pop) rp_d = (rp_q == PW'(DEPTH - 1)) ? '0 : rp_q + PW'(1);
      assert (credits_q <= CW'(DEPTH));
   end

   always_ff @(posedge acr_clk or negedge acr_rst) begin
      if (!acr_rst) begin
         state_q      <= IDLE;
         stride_q     <= '0;
         line_addr_q  <= '0;
         araddr_q     <= '0;
         line_beats_q <= '0;
         lines_q      <= '0;
         line_q       <= '0;
         beats_left_q <= '0;
         wbeat_q      <= '0;
         wline_q      <= '0;
         err_q        <= 1'b0;
         done_q       <= 1'b0;
         rx_done_q    <= 1'b0;
         credits_q    <= CW'(DEPTH);
         cnt_q        <= '0;
         wp_q         <= '0;
         rp_q         <= '0;
      end else begin
         state_q      <= state_d;
         stride_q     <= stride_d;
         line_addr_q  <= line_addr_d;
         araddr_q     <= araddr_d;
         line_beats_q <= line_beats_d;
         lines_q      <= lines_d;
         line_q       <= line_d;
         beats_left_q <= beats_left_d;
         wbeat_q      <= wbeat_d;
         wline_q      <= wline_d;
         err_q        <= err_d;
         done_q       <= done_d;
         rx_done_q    <= rx_done_d;
         credits_q    <= credits_d;
         cnt_q        <= cnt_d;
         wp_q         <= wp_d;
         rp_q         <= rp_d;
      end
   end

   always_ff @(posedge acr_clk) begin
      if (r_hs) mem_q[wp_q] <= {wr_eof, wr_eol, wr_sol, axi_rdata};
   end

endmodule
